// File: rtl/bg_tile_renderer.sv
// Scrolling tile-map background renderer: four-stage fixed-latency pipeline that turns a
// pixel coordinate into a colour through a tile-map RAM lookup and a tile-sheet ROM lookup.
module bg_tile_renderer #(
    parameter int          TILE_COLS = 40,
    parameter int          TILE_ROWS = 30,
    parameter logic [11:0] KEY_COLOR = 12'hF0F,
    parameter logic [11:0] SKY_COLOR = 12'h6AF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [3:0]  bg_x_offset,
    output logic [15:0] bg_rd_addr,
    input  logic [31:0] bg_rd_data,
    output logic [13:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb,
    output logic        rgb_valid
);

    localparam logic [10:0] LINE_PX = 11'd640;
    localparam logic [10:0] ROWS_PX = 11'(TILE_ROWS * 16);

    function automatic logic [11:0] pick_color(input logic vld, input logic en,
                                               input logic [11:0] texel);
        if (!vld)
            return 12'h000;
        else if (!en || texel == KEY_COLOR)
            return SKY_COLOR;
        else
            return texel;
    endfunction

    function automatic logic [3:0] flip4(input logic flip, input logic [3:0] v);
        return flip ? 4'd15 - v : v;
    endfunction

    logic [10:0] ex_raw;
    logic [10:0] ex_wrap;
    logic        visible;
    logic [15:0] addr_next;

    always_comb begin
        ex_raw    = {1'b0, x} + {7'b0, bg_x_offset};
        ex_wrap   = (ex_raw >= LINE_PX) ? ex_raw - LINE_PX : ex_raw;
        visible   = video_on && ({1'b0, x} < LINE_PX) && ({1'b0, y} < ROWS_PX);
        addr_next = 16'(ex_wrap[10:4]) + 16'(y[9:4]) * 16'(TILE_COLS);
    end

    // Stage 0: tile-map address plus in-tile pixel position
    logic [15:0] bg_rd_addr_p0;
    logic [3:0]  px_p0;
    logic [3:0]  py_p0;
    logic        vld_p0;

    always_ff @(posedge clk) begin
        if (reset) begin
            bg_rd_addr_p0 <= '0;
            px_p0         <= '0;
            py_p0         <= '0;
            vld_p0        <= 1'b0;
        end else begin
            bg_rd_addr_p0 <= addr_next;
            px_p0         <= ex_wrap[3:0];
            py_p0         <= y[3:0];
            vld_p0        <= visible;
        end
    end

    // Stage 1: position waits while the tile-map RAM produces the entry
    logic [3:0] px_p1;
    logic [3:0] py_p1;
    logic       vld_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            px_p1  <= '0;
            py_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            px_p1  <= px_p0;
            py_p1  <= py_p0;
            vld_p1 <= vld_p0;
        end
    end

    // Stage 2: flipped texel address into the tile sheet
    logic [13:0] rom_addr_p2;
    logic        en_p2;
    logic        vld_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr_p2 <= '0;
            en_p2       <= 1'b0;
            vld_p2      <= 1'b0;
        end else begin
            rom_addr_p2 <= {bg_rd_data[5:3], flip4(bg_rd_data[7], py_p1),
                            bg_rd_data[2:0], flip4(bg_rd_data[6], px_p1)};
            en_p2       <= bg_rd_data[8];
            vld_p2      <= vld_p1;
        end
    end

    // Stage 3: flags line up with the texel returned by the ROM
    logic en_p3;
    logic vld_p3;

    always_ff @(posedge clk) begin
        if (reset) begin
            en_p3  <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            en_p3  <= en_p2;
            vld_p3 <= vld_p2;
        end
    end

    // Upper entry bits are reserved for the game engine.
    logic unused_entry_bits;
    assign unused_entry_bits = ^bg_rd_data[31:9];

    assign bg_rd_addr = bg_rd_addr_p0;
    assign rom_addr   = rom_addr_p2;
    assign rgb        = pick_color(vld_p3, en_p3, rom_data);
    assign rgb_valid  = vld_p3;

endmodule
